// File: rtl/syn_pkg.sv
// rtl/syn_pkg.sv - shared types and constants for the spike synapse family
package syn_pkg;
   localparam int CUR_W = 8;
   localparam logic [CUR_W-1:0] CUR_MAX = 8'd255;

   typedef enum logic {
      SYN_IDLE,
      SYN_ACTIVE
   } syn_state_e;
endpackage

// File: rtl/spike_synapse_if.sv
// rtl/spike_synapse_if.sv - spike input, weight load and current output bundle
interface spike_synapse_if;
   import syn_pkg::*;

   logic             spike_in;
   logic [CUR_W-1:0] weight_in;
   logic             weight_load;
   logic [CUR_W-1:0] current;
   logic             event_out;
   logic             active;

   modport master (
      output spike_in, weight_in, weight_load,
      input  current, event_out, active
   );

   modport slave (
      input  spike_in, weight_in, weight_load,
      output current, event_out, active
   );
endinterface

// File: rtl/syn_decay.sv
// rtl/syn_decay.sv - one exponential decay step of a current value
// A nonzero current always loses at least 1 so it is guaranteed to reach 0.
module syn_decay
   import syn_pkg::*;
#(
   parameter int DECAY_SHIFT = 3
) (
   input  logic [CUR_W-1:0] cur,
   input  logic             tick,
   output logic [CUR_W-1:0] cur_dec
);
   logic [CUR_W-1:0] dec;

   always_comb begin
      dec = cur >> DECAY_SHIFT;
      if (dec == '0 && cur != '0) begin
         dec = CUR_W'(1);
      end
      cur_dec = tick ? (cur - dec) : cur;
   end
endmodule

// File: rtl/spike_synapse.sv
// rtl/spike_synapse.sv - current-based synapse: edge-counted spikes, weighted add, prescaled decay
// Optional refractory window enabled by defining SYN_REFRACT_EN.
module spike_synapse
   import syn_pkg::*;
#(
   parameter logic [CUR_W-1:0] WEIGHT_INIT    = 8'd32,
   parameter int               DECAY_DIV      = 16,
   parameter int               DECAY_SHIFT    = 3,
   parameter int               REFRACT_CYCLES = 4
) (
   input logic           clk,
   input logic           reset,
   spike_synapse_if.slave syn
);
   localparam int PW = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(DECAY_DIV - 1);

   if (DECAY_DIV < 2 || DECAY_SHIFT < 1 || DECAY_SHIFT > 7 || REFRACT_CYCLES < 1) begin : g_param_check
      $error("spike_synapse: parameter out of range");
   end

   syn_state_e       state_q, state_d;
   logic             spike_q, spike_d;
   logic [CUR_W-1:0] weight_q, weight_d;
   logic [CUR_W-1:0] cur_q, cur_d;
   logic             ev_q, ev_d;
   logic [PW-1:0]    pre_q, pre_d;

   logic             raw_ev, accept, tick, refr_busy;
   logic [CUR_W-1:0] cur_dec;
   logic [CUR_W:0]   sum;

`ifdef SYN_REFRACT_EN
   localparam int RW = $clog2(REFRACT_CYCLES + 1);
   logic [RW-1:0] refr_q, refr_d;

   // Free-running down-counter, deliberately not tied to the FSM state.
   always_comb begin
      refr_d = refr_q;
      if (accept) begin
         refr_d = RW'(REFRACT_CYCLES);
      end else if (refr_q != '0) begin
         refr_d = refr_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         refr_q <= '0;
      end else begin
         refr_q <= refr_d;
      end
   end

   assign refr_busy = (refr_q != '0);
`else
   assign refr_busy = 1'b0;
`endif

   syn_decay #(.DECAY_SHIFT(DECAY_SHIFT)) u_decay (
      .cur     (cur_q),
      .tick    (tick),
      .cur_dec (cur_dec)
   );

   always_comb begin
      raw_ev   = syn.spike_in & ~spike_q;
      accept   = raw_ev & ~refr_busy;
      tick     = (state_q == SYN_ACTIVE) && (pre_q == PRE_LAST);
      sum      = {1'b0, cur_dec} + {1'b0, weight_q};
      cur_d    = cur_dec;
      if (accept) begin
         cur_d = sum[CUR_W] ? CUR_MAX : sum[CUR_W-1:0];
      end
      // The event above still sees the old weight when a load coincides.
      weight_d = syn.weight_load ? syn.weight_in : weight_q;
      spike_d  = syn.spike_in;
      ev_d     = accept;
      state_d  = state_q;
      pre_d    = '0;
      case (state_q)
         SYN_IDLE: begin
            if (accept && weight_q != '0) begin
               state_d = SYN_ACTIVE;
            end
         end
         SYN_ACTIVE: begin
            if (cur_d == '0) begin
               state_d = SYN_IDLE;
            end else begin
               pre_d = tick ? '0 : pre_q + 1'b1;
            end
         end
         default: state_d = SYN_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= SYN_IDLE;
         spike_q  <= 1'b0;
         weight_q <= WEIGHT_INIT;
         cur_q    <= '0;
         ev_q     <= 1'b0;
         pre_q    <= '0;
      end else begin
         state_q  <= state_d;
         spike_q  <= spike_d;
         weight_q <= weight_d;
         cur_q    <= cur_d;
         ev_q     <= ev_d;
         pre_q    <= pre_d;
      end
   end

   assign syn.current   = cur_q;
   assign syn.event_out = ev_q;
   assign syn.active    = (state_q == SYN_ACTIVE);
endmodule
